pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage 8-bit pipeline. It decides each cycle whether the PC, IF/ID and ID/EX registers advance, stall, or are flushed.
- Load-use hazards insert a bubble into ID/EX.
- Taken branches resolved in MEM flush the three younger stages.
- An external memory hold freezes the front end.
- A small FSM sequences multi-cycle flush and hold episodes so hazards are not re-detected mid-episode.

Parameters:
- FLUSH_CYCLES, 1, cycles the flush outputs stay asserted after a taken branch (1..7).
- R0_ZERO, 1, when 1, a destination of register 0 never creates a load-use hazard.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_rs  in  3  source register 1 of the instruction in ID (ins[10:8])
- id_rt  in  3  source register 2 of the instruction in ID (ins[7:5])
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_mem_read  in  1  instruction in EX (ID/EX output) is a load
- ex_reg_write  in  1  ID/EX WB_reg_write_signal
- ex_rd  in  3  ID/EX destination register (out_ins1311)
- mem_branch_taken  in  1  EX/MEM MEM_pc_src, branch taken
- ext_hold  in  1  data/instruction memory busy
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_bubble  out  1  force ID/EX control fields (EX/MEM/WB) to 0
- exmem_flush  out  1  clear EX/MEM control fields
- ctrl_state  out  2  current FSM state

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high: sampled on the rising edge of clk. No asynchronous paths.
- FSM states:
  - RUN=0
  - LSTALL=1 (load-use bubble cycle)
  - FLUSH=2
  - HOLD=3
- Outputs are Mealy: combinational from the state plus the current inputs. State updates on posedge clk.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_mem_read && ex_reg_write
  - (id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)
  - if R0_ZERO=1: ex_rd!=0
- Priority within a cycle: rst > mem_branch_taken > ext_hold > lu.
- rst=1:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - Next state RUN; flush counter cleared.
  - This applies even mid-FLUSH or mid-HOLD.
- RUN:
  - Default outputs: pc_write=1, ifid_write=1, all others 0.
  - mem_branch_taken: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1 (PC loads the target).
    - If FLUSH_CYCLES>1: next state FLUSH, counter=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - ext_hold (no branch): pc_write=0, ifid_write=0, idex_bubble=1; next state HOLD.
  - lu (no branch, no hold): pc_write=0, ifid_write=0, idex_bubble=1; next state LSTALL.
- LSTALL:
  - Lasts exactly one cycle. Outputs as in RUN, with lu masked.
  - Next state RUN, unless a branch or hold applies, in which case follow the RUN rules.
- FLUSH:
  - Outputs: ifid_flush=1, idex_bubble=1, exmem_flush=0, pc_write=1.
  - Counter decrements each cycle; next state RUN when counter reaches 1.
  - A new mem_branch_taken reloads the counter and asserts exmem_flush.
  - ext_hold and lu are ignored in this state.
- HOLD:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - Stays in HOLD while ext_hold=1. When ext_hold=0, outputs follow the RUN rules for that cycle and the next state is RUN.
  - A mem_branch_taken during HOLD takes priority: flush outputs are driven and the state leaves HOLD via the RUN branch rule.
- ctrl_state reflects the registered state; it is RUN after reset.
- ifid_flush and ifid_write may both be 1; the flush wins at the IF/ID register.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN
- When defined, adds three outputs: stall_cnt[15:0], flush_cnt[15:0] and hold_cnt[15:0].
  - Each is a saturating counter (stops at 0xFFFF).
  - They increment on cycles with lu-stall, branch flush (entry cycle only) and HOLD state respectively.
  - All are cleared by rst.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. Reset: rst=1 for 2 cycles while mem_branch_taken=1 -> ctrl_state=0; ifid_flush=idex_bubble=exmem_flush=1; pc_write=0; after release pc_write=1, ifid_write=1.
2. Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle with pc_write=0 and idex_bubble=1, ctrl_state=1 next cycle, then 0. Repeat with ex_rd=0 and R0_ZERO=1 -> no stall.
3. Branch, FLUSH_CYCLES=3: mem_branch_taken pulse -> exmem_flush=1 for 1 cycle; ifid_flush=idex_bubble=1 for 3 cycles; concurrent lu ignored; ctrl_state 2,2,0.
4. Hold: ext_hold=1 for 4 cycles with lu true -> pc_write=0 for 4 cycles, ctrl_state=3, then the lu stall follows on release.
5. Branch during HOLD: ext_hold=1, then mem_branch_taken=1 -> flush outputs that same cycle, pc_write=1, HOLD exited.
6. HAZARD_PERF_CNT_EN: 70000 hold cycles -> hold_cnt=0xFFFF (saturated); rst clears all three counters to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) supplies hazard sources; the controller (slave) returns stage enables.
interface pipeline_hazard_ctrl_if;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic       ex_reg_write;
  logic [2:0] ex_rd;
  logic       mem_branch_taken;
  logic       ext_hold;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_flush;
  logic [1:0] ctrl_state;

  // Controls are level enables sampled by the pipeline registers on every rising clk edge;
  // there is no valid/ready exchange, a 0 on a write enable simply holds that register.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_rd,
           mem_branch_taken, ext_hold,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, ctrl_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_rd,
           mem_branch_taken, ext_hold,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory holds.
// Optional saturating performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter bit R0_ZERO      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] hold_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    HOLD   = 2'd3
  } ctrl_state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lu;
  logic        lu_stall;
  logic        br_take;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;

  always_comb begin
    lu = hz.ex_mem_read && hz.ex_reg_write &&
         ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
          (hz.id_uses_rt && (hz.id_rt == hz.ex_rd))) &&
         (!R0_ZERO || (hz.ex_rd != 3'd0));
  end

  // Priority chain: reset, branch, in-progress flush, hold, load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    lu_stall    = 1'b0;
    br_take     = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = 3'd0;
    end else if (hz.mem_branch_taken) begin
      br_take     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end else if (state_q == FLUSH) begin
      // Younger stages keep getting squashed; EX/MEM already holds valid post-branch work.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (cnt_q <= 3'd1) begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = 3'(cnt_q - 3'd1);
      end
    end else if (hz.ext_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = HOLD;
    end else if (lu && (state_q != LSTALL)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      lu_stall    = 1'b1;
      state_d     = LSTALL;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.exmem_flush = exmem_flush;
  assign hz.ctrl_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (lu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (br_take && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    if ((state_q == HOLD) && (hold_cnt_q != 16'hFFFF)) hold_cnt_d = hold_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      hold_cnt_q  <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign hold_cnt  = hold_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lu_stall ^ br_take;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, R0_ZERO=1).
// Output vectors are {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, hold_cnt;
`endif

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .R0_ZERO     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .hold_cnt (hold_cnt)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11111;
  localparam logic [4:0] O_FL    = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b00111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_lu(input logic mr, input logic rw, input logic [2:0] rd,
                        input logic [2:0] rs, input logic urs,
                        input logic [2:0] rt, input logic urt);
    hz.ex_mem_read  = mr;
    hz.ex_reg_write = rw;
    hz.ex_rd        = rd;
    hz.id_rs        = rs;
    hz.id_uses_rs   = urs;
    hz.id_rt        = rt;
    hz.id_uses_rt   = urt;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp_v);
    logic [4:0] obs;
    obs = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.exmem_flush};
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp_v);
    tests++;
    assert (hz.ctrl_state === exp_v)
    else begin
      fails++;
      $error("FAIL %s ctrl_state observed=%0d expected=%0d", tag, hz.ctrl_state, exp_v);
    end
  endtask

  task automatic chk_both(input string tag, input logic [4:0] exp_o, input logic [1:0] exp_s);
    chk_out(tag, exp_o);
    chk_st(tag, exp_s);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    hz.mem_branch_taken = 1'b1;
    hz.ext_hold = 1'b0;
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);

    // Reset held for two cycles with a branch pending
    settle();
    chk_out("rst_c0", O_RST);
    tick();
    chk_both("rst_c1", O_RST, 2'd0);
    tick();
    chk_both("rst_c2", O_RST, 2'd0);
    rst = 1'b0;
    hz.mem_branch_taken = 1'b0;
    settle();
    chk_both("rst_release", O_RUN, 2'd0);

    // Load-use through rs
    tick();
    set_lu(1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    settle();
    chk_both("lu_rs_stall", O_STALL, 2'd0);
    tick();
    chk_both("lu_rs_masked", O_RUN, 2'd1);
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    chk_both("lu_rs_back", O_RUN, 2'd0);

    // Load-use through rt
    set_lu(1'b1, 1'b1, 3'd5, 3'd1, 1'b0, 3'd5, 1'b1);
    settle();
    chk_both("lu_rt_stall", O_STALL, 2'd0);
    tick();
    chk_st("lu_rt_lstall", 2'd1);
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();

    // Non-hazards: r0 destination, source unused, no reg write, no load
    set_lu(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
    settle();
    chk_out("lu_r0", O_RUN);
    set_lu(1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0);
    settle();
    chk_out("lu_unused", O_RUN);
    set_lu(1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0);
    settle();
    chk_out("lu_no_wr", O_RUN);
    set_lu(1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0);
    settle();
    chk_out("lu_no_load", O_RUN);
    tick();
    chk_st("lu_none_run", 2'd0);

    // Branch with concurrent load-use: 3 flush cycles, lu ignored while flushing
    set_lu(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0);
    hz.mem_branch_taken = 1'b1;
    settle();
    chk_both("br_entry", O_BR, 2'd0);
    tick();
    hz.mem_branch_taken = 1'b0;
    settle();
    chk_both("br_fl1", O_FL, 2'd2);
    tick();
    chk_both("br_fl2", O_FL, 2'd2);
    tick();
    chk_both("br_done_lu", O_STALL, 2'd0);
    tick();
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    settle();
    chk_both("br_lstall", O_RUN, 2'd1);
    tick();

    // Second branch during FLUSH reloads the counter
    hz.mem_branch_taken = 1'b1;
    tick();
    settle();
    chk_both("br_reload", O_BR, 2'd2);
    tick();
    hz.mem_branch_taken = 1'b0;
    settle();
    chk_both("br_reload_fl1", O_FL, 2'd2);
    tick();
    chk_both("br_reload_fl2", O_FL, 2'd2);
    tick();
    chk_both("br_reload_end", O_RUN, 2'd0);

    // Hold for four cycles with lu pending, then the stall on release
    set_lu(1'b1, 1'b1, 3'd6, 3'd6, 1'b1, 3'd0, 1'b0);
    hz.ext_hold = 1'b1;
    settle();
    chk_both("hold_c1", O_STALL, 2'd0);
    tick();
    chk_both("hold_c2", O_STALL, 2'd3);
    tick();
    chk_both("hold_c3", O_STALL, 2'd3);
    tick();
    chk_both("hold_c4", O_STALL, 2'd3);
    hz.ext_hold = 1'b0;
    settle();
    chk_both("hold_release_lu", O_STALL, 2'd3);
    tick();
    chk_both("hold_lstall", O_RUN, 2'd1);
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    chk_both("hold_back_run", O_RUN, 2'd0);

    // Branch during HOLD
    hz.ext_hold = 1'b1;
    tick();
    chk_st("hb_in_hold", 2'd3);
    hz.mem_branch_taken = 1'b1;
    settle();
    chk_both("hb_branch", O_BR, 2'd3);
    tick();
    hz.mem_branch_taken = 1'b0;
    hz.ext_hold = 1'b0;
    settle();
    chk_both("hb_flush", O_FL, 2'd2);
    tick();
    tick();
    chk_both("hb_run", O_RUN, 2'd0);

    // Reset in the middle of a flush episode
    hz.mem_branch_taken = 1'b1;
    tick();
    hz.mem_branch_taken = 1'b0;
    rst = 1'b1;
    settle();
    chk_both("rst_mid_flush", O_RST, 2'd2);
    tick();
    rst = 1'b0;
    settle();
    chk_both("rst_mid_after", O_RUN, 2'd0);

`ifdef HAZARD_PERF_CNT_EN
    // Counters: one stall, one branch, then saturate hold, then clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_cnt("perf_rst_stall", stall_cnt, 16'd0);
    set_lu(1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 3'd0, 1'b0);
    tick();
    set_lu(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    chk_cnt("perf_stall1", stall_cnt, 16'd1);
    hz.mem_branch_taken = 1'b1;
    tick();
    hz.mem_branch_taken = 1'b0;
    tick();
    tick();
    chk_cnt("perf_flush1", flush_cnt, 16'd1);
    hz.ext_hold = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    chk_cnt("perf_hold_sat", hold_cnt, 16'hFFFF);
    hz.ext_hold = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_cnt("perf_clr_stall", stall_cnt, 16'd0);
    chk_cnt("perf_clr_flush", flush_cnt, 16'd0);
    chk_cnt("perf_clr_hold", hold_cnt, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
